// File: rtl/sample_packer.sv
// sample_packer: captures SRAM read transactions into a record FIFO and
// streams each record out as five bytes over a valid/ready byte port.
module sample_packer #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       read,
    input  logic [14:0]                R_address,
    input  logic [7:0]                 R_data,
    input  logic                       capture_en,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 39;   // {addr[14:0], data[7:0], ts[15:0]}

    typedef enum logic {IDLE, SEND} state_t;

    logic [15:0]   ts;
    logic          read_d;
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [RW-1:0] rec;
    state_t        state, state_nx;
    logic [2:0]    idx, idx_nx;

    logic capture, push, pop, fire, last;

    // handshake, pop and push decisions for this edge
    always_comb begin
        capture = read & ~read_d & capture_en;
        fire    = (state == SEND) & out_ready;
        last    = fire & (idx == 3'd4);
        // a record is loaded whenever the serializer becomes free and one waits
        pop     = (level != '0) & ((state == IDLE) | last);
        // a full FIFO still accepts when a pop frees a slot on the same edge
        push    = capture & ((level != LW'(DEPTH)) | pop);
    end

    // serializer next state and byte index
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nx = SEND;
                    idx_nx   = 3'd0;
                end
            end
            SEND: begin
                if (fire) begin
                    if (idx == 3'd4) begin
                        idx_nx = 3'd0;
                        if (!pop) state_nx = IDLE;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = 3'd0;
            end
        endcase
    end

    // output byte select; zero while idle so reset shows 0x00
    always_comb begin
        out_valid = (state == SEND);
        out_data  = 8'h00;
        if (state == SEND) begin
            case (idx)
                3'd0:    out_data = {1'b1, rec[38:32]};
                3'd1:    out_data = rec[31:24];
                3'd2:    out_data = rec[23:16];
                3'd3:    out_data = rec[15:8];
                3'd4:    out_data = rec[7:0];
                default: out_data = 8'h00;
            endcase
        end
    end

    // serializer state, index and loaded record
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
            rec   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (pop) rec <= mem[rd_ptr];
        end
    end

    // record storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= {R_address, R_data, ts};
    end

    // timestamp, edge detector, pointers, level and overflow counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ts           <= 16'h0000;
            read_d       <= 1'b1;   // blocks capture of a read already high at reset release
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow_cnt <= 8'h00;
        end else begin
            ts     <= ts + 16'd1;
            read_d <= read;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (capture && !push && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    assign fifo_level = level;

endmodule
